// File: rtl/mux_n_rr.sv
// N-channel data mux with manual select or round-robin scan,
// feeding a single registered output slot with valid/ready flow control.
module mux_n_rr #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          y_chan
);

  logic [WIDTH-1:0]    r_y;
  logic                r_valid;
  logic [SEL_W-1:0]    r_chan;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_load_en;
  logic                w_sel_ok;
  logic                w_man_hit;
  logic                w_scan_hit;
  logic [SEL_W-1:0]    w_scan_idx;
  logic                w_hit;
  logic [SEL_W-1:0]    w_idx;
  logic                w_grant;
  logic [CHANNELS-1:0] w_ready;
  logic [WIDTH-1:0]    w_data;
  logic [SEL_W-1:0]    w_ptr_nxt;
  int                  w_k;

  assign w_load_en = !r_valid || out_ready;

  assign w_sel_ok  = int'(sel) < CHANNELS;

  always_comb begin
    w_man_hit = 1'b0;
    if (w_sel_ok) begin
      w_man_hit = in_valid[sel];
    end
  end

  // Search upward from r_ptr with wrap; first hit wins.
  always_comb begin
    w_scan_hit = 1'b0;
    w_scan_idx = '0;
    w_k        = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_k = (int'(r_ptr) + i) % CHANNELS;
      if (!w_scan_hit && in_valid[w_k]) begin
        w_scan_hit = 1'b1;
        w_scan_idx = SEL_W'(w_k);
      end
    end
  end

  assign w_hit   = mode ? w_scan_hit : w_man_hit;
  assign w_idx   = mode ? w_scan_idx : sel;
  assign w_grant = rst_n && w_hit && w_load_en;

  always_comb begin
    w_ready = '0;
    w_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SEL_W'(k) == w_idx) begin
        w_ready[k] = w_grant;
        w_data     = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_idx == SEL_W'(CHANNELS - 1))
                   ? '0 : w_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_grant) begin
        r_y     <= w_data;
        r_chan  <= w_idx;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_grant && mode) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign in_ready = w_ready;
  assign y        = r_y;
  assign y_valid  = r_valid;
  assign y_chan   = r_chan;

endmodule
